// File: rtl/ucsbece154b_branch_resolve_pkg.sv
// rtl/ucsbece154b_branch_resolve_pkg.sv - opcodes and control classification for E-stage branch resolution
package ucsbece154b_branch_resolve_pkg;

  localparam logic [6:0] instr_branch_op = 7'b1100011;
  localparam logic [6:0] instr_jal_op    = 7'b1101111;
  localparam logic [6:0] instr_jalr_op   = 7'b1100111;

  typedef enum logic [1:0] {
    CTRL_NONE,
    CTRL_BRANCH,
    CTRL_JUMP
  } ctrl_kind_e;

  // jal and jalr are always taken, so they share one class
  function automatic ctrl_kind_e classify_op(input logic [6:0] op);
    if (op == instr_branch_op) return CTRL_BRANCH;
    if (op == instr_jal_op || op == instr_jalr_op) return CTRL_JUMP;
    return CTRL_NONE;
  endfunction

endpackage

// File: rtl/ucsbece154b_sat_counter.sv
// rtl/ucsbece154b_sat_counter.sv - saturating event counter with synchronous clear
module ucsbece154b_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  // clear wins over a same-cycle increment; the count sticks at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ucsbece154b_branch_resolve.sv
// rtl/ucsbece154b_branch_resolve.sv - carries predictions to E, detects mispredicts, drives predictor updates
module ucsbece154b_branch_resolve
  import ucsbece154b_branch_resolve_pkg::*;
#(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS    = 5
) (
  input  logic                               clk,
  input  logic                               reset_i,
  input  logic                               stallD_i,
  input  logic                               flushD_i,
  input  logic                               flushE_i,
  input  logic [31:0]                        pcF_i,
  input  logic                               BranchTakenF_i,
  input  logic [31:0]                        BTBtargetF_i,
  input  logic [NUM_GHR_BITS-1:0]            PHTreadaddressF_i,
  input  logic [6:0]                         opE_i,
  input  logic                               ActualTakenE_i,
  input  logic [31:0]                        ActualTargetE_i,
  input  logic                               countersClear_i,
  output logic                               MispredictE_o,
  output logic [31:0]                        RedirectPC_o,
  output logic                               BTB_we_o,
  output logic [$clog2(NUM_BTB_ENTRIES)-1:0] BTBwriteaddress_o,
  output logic [31:0]                        BTBwritedata_o,
  output logic                               PHTwe_o,
  output logic                               PHTincrement_o,
  output logic [NUM_GHR_BITS-1:0]            PHTwriteaddress_o,
  output logic                               GHRreset_o,
  output logic [31:0]                        BranchCount_o,
  output logic [31:0]                        MispredictCount_o
);

  localparam int BTB_IDX_W = $clog2(NUM_BTB_ENTRIES);

  logic [31:0]             pcD, pred_targetD;
  logic                    pred_takenD, validD;
  logic [NUM_GHR_BITS-1:0] pht_idxD;

  logic [31:0]             pcE, pred_targetE;
  logic                    pred_takenE, validE;
  logic [NUM_GHR_BITS-1:0] pht_idxE;

  ctrl_kind_e ctrl_e;
  logic       is_br, is_j, ctrl_valid, act_taken, target_diff;

  // F->D: flush beats stall, stall holds, otherwise capture the fetch prediction
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      validD       <= 1'b0;
      pcD          <= '0;
      pred_takenD  <= 1'b0;
      pred_targetD <= '0;
      pht_idxD     <= '0;
    end else if (flushD_i) begin
      validD <= 1'b0;
    end else if (!stallD_i) begin
      validD       <= 1'b1;
      pcD          <= pcF_i;
      pred_takenD  <= BranchTakenF_i;
      pred_targetD <= BTBtargetF_i;
      pht_idxD     <= PHTreadaddressF_i;
    end
  end

  // D->E: no stall in E, only a bubble on flush
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      validE       <= 1'b0;
      pcE          <= '0;
      pred_takenE  <= 1'b0;
      pred_targetE <= '0;
      pht_idxE     <= '0;
    end else begin
      validE       <= validD & ~flushE_i;
      pcE          <= pcD;
      pred_takenE  <= pred_takenD;
      pred_targetE <= pred_targetD;
      pht_idxE     <= pht_idxD;
    end
  end

  assign ctrl_e      = classify_op(opE_i);
  assign is_br       = (ctrl_e == CTRL_BRANCH);
  assign is_j        = (ctrl_e == CTRL_JUMP);
  assign ctrl_valid  = validE & (is_br | is_j);
  assign act_taken   = is_j | (is_br & ActualTakenE_i);
  assign target_diff = (pred_targetE != ActualTargetE_i);

  // resolve the E instruction; everything stays 0 unless a valid control op is present
  always_comb begin
    MispredictE_o     = 1'b0;
    RedirectPC_o      = '0;
    BTB_we_o          = 1'b0;
    BTBwriteaddress_o = '0;
    BTBwritedata_o    = '0;
    PHTwe_o           = 1'b0;
    PHTincrement_o    = 1'b0;
    PHTwriteaddress_o = '0;
    if (ctrl_valid) begin
      MispredictE_o = (pred_takenE != act_taken) | (pred_takenE & act_taken & target_diff);
      if (MispredictE_o) begin
        RedirectPC_o = act_taken ? ActualTargetE_i : (pcE + 32'd4);
      end
      if (act_taken && target_diff) begin
        BTB_we_o          = 1'b1;
        BTBwriteaddress_o = pcE[BTB_IDX_W+1:2];
        BTBwritedata_o    = ActualTargetE_i;
      end
      if (is_br) begin
        PHTwe_o           = 1'b1;
        PHTincrement_o    = ActualTakenE_i;
        PHTwriteaddress_o = pht_idxE;
      end
    end
  end

  assign GHRreset_o = MispredictE_o;

  ucsbece154b_sat_counter #(.WIDTH(32)) u_branch_cnt (
    .clk     (clk),
    .rst     (reset_i),
    .clear_i (countersClear_i),
    .en_i    (ctrl_valid),
    .count_o (BranchCount_o)
  );

  ucsbece154b_sat_counter #(.WIDTH(32)) u_mispredict_cnt (
    .clk     (clk),
    .rst     (reset_i),
    .clear_i (countersClear_i),
    .en_i    (MispredictE_o),
    .count_o (MispredictCount_o)
  );

endmodule

// File: tb/tb_ucsbece154b_branch_resolve.sv
// tb/tb_ucsbece154b_branch_resolve.sv - directed bench with behavioural predictor-update model
module tb_ucsbece154b_branch_resolve;

  localparam logic [6:0] OP_BR   = 7'h63;
  localparam logic [6:0] OP_JAL  = 7'h6F;
  localparam logic [6:0] OP_JALR = 7'h67;
  localparam logic [6:0] OP_NOP  = 7'h13;
  localparam logic [6:0] OP_ADD  = 7'h33;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        stallD_i, flushD_i, flushE_i;
  logic [31:0] pcF_i, BTBtargetF_i, ActualTargetE_i;
  logic        BranchTakenF_i, ActualTakenE_i, countersClear_i;
  logic [4:0]  PHTreadaddressF_i;
  logic [6:0]  opE_i;
  logic        MispredictE_o, BTB_we_o, PHTwe_o, PHTincrement_o, GHRreset_o;
  logic [31:0] RedirectPC_o, BTBwritedata_o, BranchCount_o, MispredictCount_o;
  logic [4:0]  BTBwriteaddress_o, PHTwriteaddress_o;

  ucsbece154b_branch_resolve #(.NUM_BTB_ENTRIES(32), .NUM_GHR_BITS(5)) dut (
    .clk               (clk),
    .reset_i           (reset_i),
    .stallD_i          (stallD_i),
    .flushD_i          (flushD_i),
    .flushE_i          (flushE_i),
    .pcF_i             (pcF_i),
    .BranchTakenF_i    (BranchTakenF_i),
    .BTBtargetF_i      (BTBtargetF_i),
    .PHTreadaddressF_i (PHTreadaddressF_i),
    .opE_i             (opE_i),
    .ActualTakenE_i    (ActualTakenE_i),
    .ActualTargetE_i   (ActualTargetE_i),
    .countersClear_i   (countersClear_i),
    .MispredictE_o     (MispredictE_o),
    .RedirectPC_o      (RedirectPC_o),
    .BTB_we_o          (BTB_we_o),
    .BTBwriteaddress_o (BTBwriteaddress_o),
    .BTBwritedata_o    (BTBwritedata_o),
    .PHTwe_o           (PHTwe_o),
    .PHTincrement_o    (PHTincrement_o),
    .PHTwriteaddress_o (PHTwriteaddress_o),
    .GHRreset_o        (GHRreset_o),
    .BranchCount_o     (BranchCount_o),
    .MispredictCount_o (MispredictCount_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        ptaken;
    logic [31:0] ptgt;
    logic [4:0]  pht;
  } pred_t;

  typedef struct packed {
    logic        ctrl;
    logic        mis;
    logic [31:0] rpc;
    logic        btb_we;
    logic [4:0]  btb_addr;
    logic [31:0] btb_data;
    logic        pht_we;
    logic        pht_inc;
    logic [4:0]  pht_addr;
  } exp_t;

  pred_t       md = '0, me = '0;
  logic [31:0] m_br = '0, m_mis = '0;
  logic        preload_en = 1'b0;
  logic [31:0] preload_val = '0;

  logic        lit_en = 1'b0;
  string       lit_name = "";
  exp_t        lit_out = '0;
  logic [31:0] lit_br = '0, lit_mis = '0;

  int n_checks = 0;
  int n_fail = 0;

  // what E must produce given the prediction that reached it and the actual outcome
  function automatic exp_t expect_of(input pred_t e, input logic [6:0] op,
                                     input logic at, input logic [31:0] atgt);
    exp_t r;
    logic br, j, taken;
    r = '0;
    br = (op == OP_BR);
    j = (op == OP_JAL) || (op == OP_JALR);
    if (!e.valid || !(br || j)) return r;
    taken = j || (br && at);
    r.ctrl = 1'b1;
    r.mis = (e.ptaken != taken) || (e.ptaken && taken && (e.ptgt != atgt));
    if (r.mis) r.rpc = taken ? atgt : e.pc + 32'd4;
    if (taken && (e.ptgt != atgt)) begin
      r.btb_we = 1'b1;
      r.btb_addr = 5'((e.pc / 4) % 32);
      r.btb_data = atgt;
    end
    if (br) begin
      r.pht_we = 1'b1;
      r.pht_inc = at;
      r.pht_addr = e.pht;
    end
    return r;
  endfunction

  // model: a fetched prediction moves F->D->E under the stall/flush rules; counters saturate
  always @(posedge clk or posedge reset_i) begin
    exp_t x;
    if (reset_i) begin
      md = '0;
      me = '0;
      m_br = '0;
      m_mis = '0;
    end else begin
      x = expect_of(me, opE_i, ActualTakenE_i, ActualTargetE_i);
      if (preload_en) m_mis = preload_val;
      if (countersClear_i) begin
        m_br = '0;
        m_mis = '0;
      end else begin
        if (x.ctrl && m_br != 32'hFFFFFFFF) m_br = m_br + 1;
        if (x.mis && m_mis != 32'hFFFFFFFF) m_mis = m_mis + 1;
      end
      me = md;
      if (flushE_i) me.valid = 1'b0;
      if (flushD_i) md.valid = 1'b0;
      else if (!stallD_i) md = '{1'b1, pcF_i, BranchTakenF_i, BTBtargetF_i, PHTreadaddressF_i};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // compare every cycle against the model, and against hand values where given
  always @(negedge clk) begin
    exp_t x;
    x = expect_of(me, opE_i, ActualTakenE_i, ActualTargetE_i);
    chk("mispredict", 32'(MispredictE_o), 32'(x.mis));
    chk("redirect", RedirectPC_o, x.rpc);
    chk("btb_we", 32'(BTB_we_o), 32'(x.btb_we));
    chk("btb_addr", 32'(BTBwriteaddress_o), 32'(x.btb_addr));
    chk("btb_data", BTBwritedata_o, x.btb_data);
    chk("pht_we", 32'(PHTwe_o), 32'(x.pht_we));
    chk("pht_inc", 32'(PHTincrement_o), 32'(x.pht_inc));
    chk("pht_addr", 32'(PHTwriteaddress_o), 32'(x.pht_addr));
    chk("ghr_reset", 32'(GHRreset_o), 32'(x.mis));
    chk("branch_count", BranchCount_o, m_br);
    chk("mispredict_count", MispredictCount_o, preload_en ? preload_val : m_mis);
    if (lit_en) begin
      chk({lit_name, ".mispredict"}, 32'(MispredictE_o), 32'(lit_out.mis));
      chk({lit_name, ".redirect"}, RedirectPC_o, lit_out.rpc);
      chk({lit_name, ".btb_we"}, 32'(BTB_we_o), 32'(lit_out.btb_we));
      chk({lit_name, ".btb_addr"}, 32'(BTBwriteaddress_o), 32'(lit_out.btb_addr));
      chk({lit_name, ".btb_data"}, BTBwritedata_o, lit_out.btb_data);
      chk({lit_name, ".pht_we"}, 32'(PHTwe_o), 32'(lit_out.pht_we));
      chk({lit_name, ".pht_inc"}, 32'(PHTincrement_o), 32'(lit_out.pht_inc));
      chk({lit_name, ".pht_addr"}, 32'(PHTwriteaddress_o), 32'(lit_out.pht_addr));
      chk({lit_name, ".ghr_reset"}, 32'(GHRreset_o), 32'(lit_out.mis));
      chk({lit_name, ".branch_count"}, BranchCount_o, lit_br);
      chk({lit_name, ".mispredict_count"}, MispredictCount_o, lit_mis);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_f(input logic [31:0] pc, input logic pt, input logic [31:0] tgt, input logic [4:0] pht);
    pcF_i = pc;
    BranchTakenF_i = pt;
    BTBtargetF_i = tgt;
    PHTreadaddressF_i = pht;
  endtask

  task automatic set_e(input logic [6:0] op, input logic at, input logic [31:0] tgt);
    opE_i = op;
    ActualTakenE_i = at;
    ActualTargetE_i = tgt;
  endtask

  task automatic expect_lit(input string name, input logic mis, input logic [31:0] rpc,
                            input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                            input logic phtwe, input logic inc, input logic [4:0] phtaddr,
                            input logic [31:0] brc, input logic [31:0] misc);
    lit_name = name;
    lit_out = '{1'b0, mis, rpc, we, waddr, wdata, phtwe, inc, phtaddr};
    lit_br = brc;
    lit_mis = misc;
    lit_en = 1'b1;
    @(negedge clk);
    #1;
    lit_en = 1'b0;
  endtask

  // fetch in cycle A, optional E bubble at the D->E edge, resolve in cycle C (returns in C)
  task automatic issue(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt, input logic [4:0] pht,
                       input logic [6:0] op, input logic at, input logic [31:0] atgt, input logic kill);
    set_e(OP_NOP, 1'b0, 32'd0);
    set_f(pc, pt, ptgt, pht);
    cyc();
    set_f(32'd0, 1'b0, 32'd0, 5'd0);
    flushE_i = kill;
    cyc();
    flushE_i = 1'b0;
    set_e(op, at, atgt);
  endtask

  initial begin
    stallD_i = 0; flushD_i = 0; flushE_i = 0; countersClear_i = 0;
    set_f(32'd0, 1'b0, 32'd0, 5'd0);
    set_e(OP_NOP, 1'b0, 32'd0);
    expect_lit("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    reset_i = 1'b0;

    issue(32'h100, 0, 32'h0, 5'd5, OP_BR, 1, 32'h80, 0);
    expect_lit("br_nt_to_t", 1, 32'h80, 1, 0, 32'h80, 1, 1, 5, 0, 0);
    cyc();
    issue(32'h100, 1, 32'h80, 5'd3, OP_BR, 0, 32'h80, 0);
    expect_lit("br_t_to_nt", 1, 32'h104, 0, 0, 0, 1, 0, 3, 1, 1);
    cyc();
    issue(32'h20, 1, 32'h40, 5'd7, OP_JAL, 0, 32'h40, 0);
    expect_lit("jal_ok", 0, 0, 0, 0, 0, 0, 0, 0, 2, 2);
    cyc();
    issue(32'h24, 1, 32'h200, 5'd1, OP_JALR, 0, 32'h300, 0);
    expect_lit("jalr_tgt", 1, 32'h300, 1, 9, 32'h300, 0, 0, 0, 3, 2);
    cyc();
    issue(32'h7C, 0, 32'h0, 5'd9, OP_BR, 0, 32'h90, 0);
    expect_lit("br_nt_ok", 0, 0, 0, 0, 0, 1, 0, 9, 4, 3);
    cyc();
    issue(32'h40, 1, 32'h10, 5'd12, OP_BR, 1, 32'h10, 0);
    expect_lit("br_t_ok", 0, 0, 0, 0, 0, 1, 1, 12, 5, 3);
    cyc();
    issue(32'hFFFFFFFC, 1, 32'h8, 5'd31, OP_BR, 0, 32'h8, 0);
    expect_lit("pc_wrap", 1, 32'h0, 0, 0, 0, 1, 0, 31, 6, 3);
    cyc();
    issue(32'h1F4, 1, 32'h500, 5'd4, OP_BR, 1, 32'h600, 0);
    expect_lit("br_bad_tgt", 1, 32'h600, 1, 29, 32'h600, 1, 1, 4, 7, 4);
    cyc();
    issue(32'h50, 1, 32'h99, 5'd2, OP_ADD, 1, 32'h80, 0);
    expect_lit("non_ctrl", 0, 0, 0, 0, 0, 0, 0, 0, 8, 5);
    cyc();
    issue(32'h100, 0, 32'h0, 5'd5, OP_BR, 1, 32'h80, 1);
    expect_lit("flush_e", 0, 0, 0, 0, 0, 0, 0, 0, 8, 5);
    cyc();

    set_e(OP_NOP, 1'b0, 32'd0);
    flushE_i = 1'b1;
    set_f(32'h300, 1'b0, 32'd0, 5'd2);
    cyc();
    for (int i = 0; i < 3; i++) begin
      stallD_i = 1'b1;
      flushE_i = 1'b1;
      set_f(32'h400 + 32'(i * 4), 1'b1, 32'h80, 5'd7);
      set_e(OP_BR, 1'b1, 32'h80);
      expect_lit("stall_hold", 0, 0, 0, 0, 0, 0, 0, 0, 8, 5);
      cyc();
    end
    flushD_i = 1'b1;
    expect_lit("stall_flush", 0, 0, 0, 0, 0, 0, 0, 0, 8, 5);
    cyc();
    stallD_i = 1'b0; flushD_i = 1'b0; flushE_i = 1'b0;
    set_f(32'd0, 1'b0, 32'd0, 5'd0);
    expect_lit("after_flush1", 0, 0, 0, 0, 0, 0, 0, 0, 8, 5);
    cyc();
    expect_lit("after_flush2", 0, 0, 0, 0, 0, 0, 0, 0, 8, 5);
    cyc();

    set_e(OP_NOP, 1'b0, 32'd0);
    preload_val = 32'hFFFFFFFE;
    preload_en = 1'b1;
    force dut.u_mispredict_cnt.count_q = 32'hFFFFFFFE;
    cyc();
    release dut.u_mispredict_cnt.count_q;
    preload_en = 1'b0;
    issue(32'h100, 0, 32'h0, 5'd5, OP_BR, 1, 32'h80, 0);
    expect_lit("sat_first", 1, 32'h80, 1, 0, 32'h80, 1, 1, 5, 8, 32'hFFFFFFFE);
    cyc();
    issue(32'h100, 0, 32'h0, 5'd5, OP_BR, 1, 32'h80, 0);
    expect_lit("sat_second", 1, 32'h80, 1, 0, 32'h80, 1, 1, 5, 9, 32'hFFFFFFFF);
    cyc();
    issue(32'h100, 0, 32'h0, 5'd5, OP_BR, 1, 32'h80, 0);
    countersClear_i = 1'b1;
    expect_lit("sat_hold", 1, 32'h80, 1, 0, 32'h80, 1, 1, 5, 10, 32'hFFFFFFFF);
    cyc();
    countersClear_i = 1'b0;
    issue(32'h20, 1, 32'h40, 5'd7, OP_JAL, 0, 32'h40, 0);
    expect_lit("after_clear", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();

    issue(32'h100, 0, 32'h0, 5'd5, OP_BR, 1, 32'h80, 0);
    #2;
    reset_i = 1'b1;
    expect_lit("async_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    reset_i = 1'b0;
    issue(32'h24, 1, 32'h200, 5'd1, OP_JALR, 0, 32'h300, 0);
    expect_lit("post_reset", 1, 32'h300, 1, 9, 32'h300, 0, 0, 0, 0, 0);
    cyc();
    set_e(OP_NOP, 1'b0, 32'd0);
    expect_lit("final_counts", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
